// File: rtl/modulo_demux4_1_tdm_pkg.sv
`default_nettype none
// ============================================================================
// modulo_demux4_1_tdm_pkg : shared state and slot encodings for the TDM demux
// Revision: 1.0
// ============================================================================
package modulo_demux4_1_tdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

endpackage
`default_nettype wire

// File: rtl/modulo_demux4_1_tdm_if.sv
`default_nettype none
// ============================================================================
// modulo_demux4_1_tdm_if : TDM line in, four de-multiplexed channels out
// Revision: 1.0
// ============================================================================
interface modulo_demux4_1_tdm_if #(
    parameter int W = 1
);
    logic [W-1:0] din;
    logic         sync;
    logic         en;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic [W-1:0] D;
    logic         frame_valid;
    logic         frame_err;
    logic         busy;
    logic [1:0]   slot;

    modport master (
        output din, sync, en,
        input  A, B, C, D, frame_valid, frame_err, busy, slot
    );

    modport slave (
        input  din, sync, en,
        output A, B, C, D, frame_valid, frame_err, busy, slot
    );
endinterface
`default_nettype wire

// File: rtl/modulo_decod2_4.sv
`default_nettype none
// ============================================================================
// modulo_decod2_4 : 2-to-4 one-hot decoder with enable, gate-level form
// Revision: 1.0
// ============================================================================
module modulo_decod2_4 (
    input  wire logic [1:0] sel,
    input  wire logic       en,
    output logic      [3:0] y
);
    logic [1:0] sel_n;

    assign sel_n = ~sel;

    assign y[0] = en & sel_n[1] & sel_n[0];
    assign y[1] = en & sel_n[1] & sel[0];
    assign y[2] = en & sel[1]   & sel_n[0];
    assign y[3] = en & sel[1]   & sel[0];
endmodule
`default_nettype wire

// File: rtl/modulo_demux4_1_tdm.sv
`default_nettype none
// ============================================================================
// modulo_demux4_1_tdm : frame-aligned 1:4 TDM demux, A..D update once per frame
// Revision: 1.0
// ============================================================================
module modulo_demux4_1_tdm
    import modulo_demux4_1_tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    modulo_demux4_1_tdm_if.slave   bus
);
    state_t         state_q, state_d;
    logic [1:0]     slot_q, slot_d;
    logic           fv_q, fv_d;
    logic           fe_q, fe_d;
    logic [W-1:0]   s0_q, s1_q, s2_q;
    logic [W-1:0]   a_q, b_q, c_q, d_q;

    logic           wr_stb;
    logic [1:0]     wr_sel;
    logic [3:0]     ld;

    // A sync always restarts the frame, so it forces the decoder onto slot A.
    assign wr_stb = bus.en & (bus.sync | (state_q == RUN));
    assign wr_sel = bus.sync ? SLOT_A : slot_q;

    modulo_decod2_4 u_decod (
        .sel (wr_sel),
        .en  (wr_stb),
        .y   (ld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= SLOT_A;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        fv_d    = 1'b0;
        fe_d    = 1'b0;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (bus.sync) begin
                        state_d = RUN;
                        slot_d  = SLOT_B;
                    end
                end
                RUN: begin
                    if (bus.sync) begin
                        fe_d   = 1'b1;
                        slot_d = SLOT_B;
                    end else if (slot_q == SLOT_D) begin
                        state_d = IDLE;
                        slot_d  = SLOT_A;
                        fv_d    = 1'b1;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    slot_d  = SLOT_A;
                end
            endcase
        end
    end

    // Shadow registers hold A..C until slot D completes the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            d_q  <= '0;
        end else begin
            if (ld[0]) s0_q <= bus.din;
            if (ld[1]) s1_q <= bus.din;
            if (ld[2]) s2_q <= bus.din;
            if (ld[3]) begin
                a_q <= s0_q;
                b_q <= s1_q;
                c_q <= s2_q;
                d_q <= bus.din;
            end
        end
    end

    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.C           = c_q;
    assign bus.D           = d_q;
    assign bus.frame_valid = fv_q;
    assign bus.frame_err   = fe_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.slot        = slot_q;
endmodule
`default_nettype wire

// File: tb/tb_modulo_demux4_1_tdm.sv
`default_nettype none
// ============================================================================
// tb_modulo_demux4_1_tdm : directed self-checking bench for the TDM demux
// Revision: 1.0
// ============================================================================
module tb_modulo_demux4_1_tdm;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    modulo_demux4_1_tdm_if #(.W(W)) bus ();

    modulo_demux4_1_tdm #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag,
                           input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d,
                           input logic fv, input logic fe,
                           input logic bsy, input logic [1:0] sl);
        chk({tag, ".A"},    32'(bus.A), 32'(a));
        chk({tag, ".B"},    32'(bus.B), 32'(b));
        chk({tag, ".C"},    32'(bus.C), 32'(c));
        chk({tag, ".D"},    32'(bus.D), 32'(d));
        chk({tag, ".fv"},   32'(bus.frame_valid), 32'(fv));
        chk({tag, ".fe"},   32'(bus.frame_err), 32'(fe));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
        chk({tag, ".slot"}, 32'(bus.slot), 32'(sl));
    endtask

    // Inputs change 1 time unit after a rising edge and are checked there too.
    task automatic step(input logic e, input logic s, input logic [3:0] d);
        bus.en   = e;
        bus.sync = s;
        bus.din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.din  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.din  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2'd0);
        rst_n = 1'b1;

        // Basic frame 1,0,1,1
        step(1, 1, 4'h1); chk_all("f1.s0", 0, 0, 0, 0, 0, 0, 1, 2'd1);
        step(1, 0, 4'h0); chk("f1.s1.slot", 32'(bus.slot), 32'd2);
        step(1, 0, 4'h1); chk("f1.s2.slot", 32'(bus.slot), 32'd3);
        step(1, 0, 4'h1); chk_all("f1.done", 4'h1, 4'h0, 4'h1, 4'h1, 1, 0, 0, 2'd0);
        step(0, 0, 4'h0); chk_all("f1.after", 4'h1, 4'h0, 4'h1, 4'h1, 0, 0, 0, 2'd0);

        // Same frame with a 3-cycle stall between slots 1 and 2
        step(1, 1, 4'h1);
        step(1, 0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, i[0], 4'(i[0]));
            chk_all($sformatf("stall%0d", i), 4'h1, 4'h0, 4'h1, 4'h1, 0, 0, 1, 2'd2);
        end
        step(1, 0, 4'h1); chk("stall.s2.slot", 32'(bus.slot), 32'd3);
        step(1, 0, 4'h1); chk_all("stall.done", 4'h1, 4'h0, 4'h1, 4'h1, 1, 0, 0, 2'd0);

        // Early sync aborts the partial frame
        do_reset();
        step(1, 1, 4'hA);
        step(1, 0, 4'hB); chk("es.s1.slot", 32'(bus.slot), 32'd2);
        step(1, 1, 4'h1); chk_all("es.err", 0, 0, 0, 0, 0, 1, 1, 2'd1);
        step(1, 0, 4'h2); chk_all("es.s1", 0, 0, 0, 0, 0, 0, 1, 2'd2);
        step(1, 0, 4'h3);
        step(1, 0, 4'h4); chk_all("es.done", 4'h1, 4'h2, 4'h3, 4'h4, 1, 0, 0, 2'd0);

        // Back-to-back frames, no gap
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 0, 4'h3);
        step(1, 0, 4'h4); chk_all("bb.f1", 4'h1, 4'h2, 4'h3, 4'h4, 1, 0, 0, 2'd0);
        step(1, 1, 4'h5); chk_all("bb.s0", 4'h1, 4'h2, 4'h3, 4'h4, 0, 0, 1, 2'd1);
        step(1, 0, 4'h6); chk_all("bb.s1", 4'h1, 4'h2, 4'h3, 4'h4, 0, 0, 1, 2'd2);
        step(1, 0, 4'h7); chk_all("bb.s2", 4'h1, 4'h2, 4'h3, 4'h4, 0, 0, 1, 2'd3);
        step(1, 0, 4'h8); chk_all("bb.f2", 4'h5, 4'h6, 4'h7, 4'h8, 1, 0, 0, 2'd0);

        // Data without sync while idle is ignored
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 4'h1);
            chk_all($sformatf("nosync%0d", i), 0, 0, 0, 0, 0, 0, 0, 2'd0);
        end

        // Asynchronous reset mid-frame, then a clean frame
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 0, 4'h3);
        step(1, 0, 4'h4); chk("ar.pre.A", 32'(bus.A), 32'h1);
        step(1, 1, 4'h9);
        step(1, 0, 4'hA);
        step(1, 0, 4'hB); chk("ar.mid.slot", 32'(bus.slot), 32'd3);
        #2 rst_n = 1'b0;
        #1 chk_all("ar.async", 0, 0, 0, 0, 0, 0, 0, 2'd0);
        bus.en = 1'b0;
        #1 rst_n = 1'b1;
        step(1, 1, 4'hC);
        step(1, 0, 4'hD);
        step(1, 0, 4'hE);
        step(1, 0, 4'hF); chk_all("ar.new", 4'hC, 4'hD, 4'hE, 4'hF, 1, 0, 0, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/modulo_demux4_1_tdm.md
Name: modulo_demux4_1_tdm

Overview:
- Receive-side counterpart of the 4:1 mux. Takes one time-multiplexed W-bit line carrying four channels (A, B, C, D) in fixed slot order and de-multiplexes it into four registered outputs.
- Frame-aligned by a sync strobe marking slot 0.
- Partial frames are held in shadow registers, so A..D update together once per complete frame.
- Sits at the far end of a link whose transmitter uses the 4:1 mux driven by a 2-bit slot counter.

Parameters:
- W, 1, bit width of the line and of each channel output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  time-multiplexed data; channel for the current slot.
- sync  input  1  asserted with slot 0 (channel A) data; qualified by en.
- en  input  1  slot strobe; din/sync sampled only when high; low = stall.
- A  output  W  channel 0, registered.
- B  output  W  channel 1, registered.
- C  output  W  channel 2, registered.
- D  output  W  channel 3, registered.
- frame_valid  output  1  one-cycle pulse; A..D changed on this cycle's edge.
- frame_err  output  1  one-cycle pulse; frame aborted by an early sync.
- busy  output  1  high while a frame is partially received (state RUN).
- slot  output  2  index of the next slot expected (0..3).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, slot=0.
  - Shadow registers S0..S2 = 0.
  - A=B=C=D=0, frame_valid=0, frame_err=0, busy=0.
  - Reset mid-frame discards the partial frame; no pulse is generated.
- All actions occur on rising clk edges with en=1. With en=0, all registers hold, and frame_valid and frame_err are 0 on the next cycle.
- State IDLE:
  - en & sync: S0<=din, slot<=1, go to RUN.
  - en & !sync: din ignored, stay in IDLE, slot stays 0.
- State RUN, en & !sync:
  - slot 1: S1<=din, slot<=2.
  - slot 2: S2<=din, slot<=3.
  - slot 3: A<=S0, B<=S1, C<=S2, D<=din, all on the same edge. Also frame_valid<=1, slot<=0, go to IDLE.
- State RUN, en & sync (early sync, slot 1..3):
  - frame_err<=1, partial frame discarded; A..D unchanged.
  - Treated as a new frame start: S0<=din, slot<=1, stay in RUN.
- Pulses: frame_valid and frame_err are registered, high for exactly one cycle, and never high together.
- Latency:
  - D appears at the outputs on the same edge that samples slot 3.
  - A appears 3 enabled slots after it is sampled.
  - Back-to-back frames: sync may arrive on the enabled slot immediately after slot 3, with no gap cycle. That gives 4 slots per frame at full rate.
- busy = (state==RUN). slot always reflects the next expected index.
- Slot counter is 2 bits; it is cleared explicitly after slot 3 and never wraps past 3.

Decomposition:
- Shared package/header:
  - State encodings: IDLE=1'b0, RUN=1'b1.
  - Slot constants: SLOT_A=2'd0, SLOT_B=2'd1, SLOT_C=2'd2, SLOT_D=2'd3.
- One sub-module: modulo_decod2_4, a 2-to-4 decoder with enable (gate-level, matching the mux style).
  - Inputs: slot and the qualified write strobe.
  - Outputs: the one-hot shadow/output load enables.

Test Plan:
- Reset, then frame W=1: (en=1) sync+din=1, din=0, din=1, din=1 -> after 4th edge A=1 B=0 C=1 D=1, frame_valid high 1 cycle, busy 0, slot 0.
- Stall: same frame with en=0 for 3 cycles between slots 1 and 2 (din toggling during stall) -> identical result. During the stall slot holds 2, busy 1, no pulses.
- Early sync, W=4: sync+4'hA, 4'hB, then sync+4'h1, 4'h2, 4'h3, 4'h4.
  - frame_err pulses on the 3rd edge; A..D stay 0.
  - Afterwards A=1 B=2 C=3 D=4 with frame_valid.
- Back-to-back frames 1,2,3,4 then 5,6,7,8 with no gap -> two frame_valid pulses 4 cycles apart. Outputs 1..4, then 5..8. A..D never show a mixed frame.
- Data without sync in IDLE (en=1, din=1 for 5 cycles) -> busy 0, slot 0, outputs 0, no pulses.
- rst_n low asynchronously mid-frame (after slot 2 sampled) -> outputs immediately 0, busy 0, slot 0. After release, a full new frame decodes correctly.
